// File: rtl/inst_axi_rd_responder.sv
// inst_axi_rd_responder: an AXI read-channel responder backed by a preloadable
// word memory. It accepts one AR at a time, waits FIRST_LAT cycles, then
// streams INCR beats with registered outputs.
// Optional build macro: INST_AXI_RD_DECERR_EN. When it is defined, beats whose
// word index is past the end of memory return DECERR with zero data. When it is
// undefined, word indices wrap modulo DEPTH_WORDS.
module inst_axi_rd_responder #(
    parameter int DEPTH_WORDS = 4096,
    parameter int FIRST_LAT   = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] araddr,
    input  logic [7:0]  arlen,
    input  logic        arvalid,
    output logic        arready,
    output logic [31:0] rdata,
    output logic [1:0]  rresp,
    output logic        rlast,
    output logic        rvalid,
    input  logic        rready,
    input  logic        load_en,
    input  logic [31:0] load_addr,
    input  logic [31:0] load_data
);

    localparam int AW = $clog2(DEPTH_WORDS);
    // WAIT holds for FIRST_LAT-1 cycles. The counter therefore starts at
    // FIRST_LAT-2 and exits on zero.
    localparam logic [3:0] WAIT_INIT = 4'(FIRST_LAT > 1 ? FIRST_LAT - 2 : 0);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        BURST
    } state_t;

    state_t      state;
    logic [29:0] idx;        // word index of the beat currently presented
    logic [7:0]  remaining;  // beats still to come after the presented one
    logic [3:0]  wait_cnt;

    logic [31:0] mem [DEPTH_WORDS];

    logic [29:0] fetch_idx;
    logic [31:0] fetch_data;
    logic [1:0]  fetch_resp;

    // Preload write port. It is active in every state, including during rst.
    // NOTE: the memory array is deliberately left out of reset. Contents must
    // survive rst, and a reset loop over a RAM would prevent RAM inference.
    always_ff @(posedge clk) begin
        if (load_en) begin
            mem[load_addr[AW+1:2]] <= load_data;
        end
    end

    // Select the word index of the next beat to be registered onto the R channel.
    // NOTE: every variable assigned here receives a default first, so no latch is inferred.
    always_comb begin
        fetch_idx = idx + 30'd1;
        if (state == IDLE) begin
            fetch_idx = araddr[31:2];
        end else if (state == WAIT) begin
            fetch_idx = idx;
        end
    end

`ifdef INST_AXI_RD_DECERR_EN
    logic fetch_oor;
    logic unused_bits;
    assign fetch_oor   = (fetch_idx >> AW) != 30'd0;
    assign fetch_data  = fetch_oor ? 32'd0 : mem[fetch_idx[AW-1:0]];
    assign fetch_resp  = fetch_oor ? 2'b11 : 2'b00;
    assign unused_bits = ^{araddr[1:0], load_addr[31:AW+2], load_addr[1:0]};
`else
    logic unused_bits;
    assign fetch_data  = mem[fetch_idx[AW-1:0]];
    assign fetch_resp  = 2'b00;
    assign unused_bits = ^{araddr[1:0], load_addr[31:AW+2], load_addr[1:0],
                           fetch_idx[29:AW]};
`endif

    // Transaction FSM. All AR and R outputs are registered here.
    // NOTE: sequential state uses non-blocking assignments only. Every register
    // then samples values from before the edge, whatever order the statements appear in.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            arready   <= 1'b0;
            rvalid    <= 1'b0;
            rlast     <= 1'b0;
            rdata     <= 32'd0;
            rresp     <= 2'b00;
            idx       <= 30'd0;
            remaining <= 8'd0;
            wait_cnt  <= 4'd0;
        end else begin
            case (state)
                IDLE: begin
                    arready <= 1'b1;
                    if (arvalid && arready) begin
                        arready   <= 1'b0;
                        idx       <= araddr[31:2];
                        remaining <= arlen;
                        if (FIRST_LAT == 1) begin
                            state  <= BURST;
                            rvalid <= 1'b1;
                            rlast  <= (arlen == 8'd0);
                            rdata  <= fetch_data;
                            rresp  <= fetch_resp;
                        end else begin
                            state    <= WAIT;
                            wait_cnt <= WAIT_INIT;
                        end
                    end
                end
                WAIT: begin
                    if (wait_cnt == 4'd0) begin
                        state  <= BURST;
                        rvalid <= 1'b1;
                        rlast  <= (remaining == 8'd0);
                        rdata  <= fetch_data;
                        rresp  <= fetch_resp;
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                BURST: begin
                    if (rready) begin
                        if (rlast) begin
                            state   <= IDLE;
                            arready <= 1'b1;
                            rvalid  <= 1'b0;
                            rlast   <= 1'b0;
                            rdata   <= 32'd0;
                            rresp   <= 2'b00;
                        end else begin
                            idx       <= fetch_idx;
                            remaining <= remaining - 8'd1;
                            rlast     <= (remaining == 8'd1);
                            rdata     <= fetch_data;
                            rresp     <= fetch_resp;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_inst_axi_rd_responder.sv
// Self-checking bench for inst_axi_rd_responder. A plain array models the
// memory, and expected beats are derived from the addressing rules.
module tb_inst_axi_rd_responder;

    localparam int DEPTH = 4096;
    localparam int LAT   = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;
    logic        load_en;
    logic [31:0] load_addr;
    logic [31:0] load_data;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] mem_m [DEPTH];

    inst_axi_rd_responder #(.DEPTH_WORDS(DEPTH), .FIRST_LAT(LAT)) dut (
        .clk       (clk),
        .rst       (rst),
        .araddr    (araddr),
        .arlen     (arlen),
        .arvalid   (arvalid),
        .arready   (arready),
        .rdata     (rdata),
        .rresp     (rresp),
        .rlast     (rlast),
        .rvalid    (rvalid),
        .rready    (rready),
        .load_en   (load_en),
        .load_addr (load_addr),
        .load_data (load_data)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expected beat for an absolute word index, following the addressing rules.
    function automatic void exp_beat(input longint word, output logic [31:0] d,
                                     output logic [1:0] r);
`ifdef INST_AXI_RD_DECERR_EN
        if (word >= DEPTH) begin
            d = 32'd0;
            r = 2'b11;
        end else begin
            d = mem_m[int'(word)];
            r = 2'b00;
        end
`else
        d = mem_m[int'(word % DEPTH)];
        r = 2'b00;
`endif
    endfunction

    // rmode: 0 = rready always high, 1 = repeating 1,0,0,1 pattern, 2 = random.
    // ld_beat >= 0: load ld_data into word ld_word while that beat is presented.
    // rst_beat >= 0: assert rst while that beat is presented.
    task automatic burst(input logic [31:0] addr, input int len, input int rmode,
                         input int ld_beat, input int ld_word, input logic [31:0] ld_data,
                         input int rst_beat);
        logic [31:0] ed [256];
        logic [1:0]  er [256];
        longint      base;
        int          k;
        int          guard;
        int          phase;
        int          first;
        base = longint'(addr[31:2]);
        for (int j = 0; j <= len; j++) exp_beat(base + j, ed[j], er[j]);
        check("arready_idle", arready, 1);
        araddr  = addr;
        arlen   = len[7:0];
        arvalid = 1'b1;
        step();
        arvalid = 1'b0;
        araddr  = $urandom;
        arlen   = 8'($urandom);
        for (int i = 1; i < LAT; i++) begin
            check("wait_rvalid", rvalid, 0);
            check("wait_arready", arready, 0);
            step();
        end
        k = 0;
        guard = 0;
        phase = 0;
        while (k <= len) begin
            if (guard > 3000) begin
                check("burst_timeout_beats", k, len + 1);
                break;
            end
            if (k == rst_beat) begin
                rst = 1'b1;
                step();
                rst = 1'b0;
                check("rst_rvalid", rvalid, 0);
                check("rst_rlast", rlast, 0);
                check("rst_rdata", rdata, 0);
                check("rst_arready", arready, 0);
                step();
                check("post_rst_arready", arready, 1);
                rready = 1'b0;
                return;
            end
            case (rmode)
                0:       rready = 1'b1;
                1:       rready = (phase % 4 == 0) || (phase % 4 == 3);
                default: rready = ($urandom_range(0, 9) < 7);
            endcase
            phase++;
            check("rvalid", rvalid, 1);
            check("rdata", rdata, ed[k]);
            check("rresp", rresp, er[k]);
            check("rlast", rlast, (k == len));
            check("burst_arready", arready, 0);
            if (k == ld_beat) begin
                load_en   = 1'b1;
                load_addr = {ld_word[29:0], 2'b00};
                load_data = ld_data;
                mem_m[ld_word % DEPTH] = ld_data;
                first = rready ? k + 2 : k + 1;
                for (int j = first; j <= len; j++) exp_beat(base + j, ed[j], er[j]);
            end
            if (rready) k++;
            step();
            load_en = 1'b0;
            guard++;
        end
        check("end_rvalid", rvalid, 0);
        check("end_rlast", rlast, 0);
        check("end_arready", arready, 1);
        rready = 1'b0;
    endtask

    initial begin
        logic [31:0] a;
        rst       = 1'b1;
        araddr    = 32'd0;
        arlen     = 8'd0;
        arvalid   = 1'b0;
        rready    = 1'b0;
        load_en   = 1'b0;
        load_addr = 32'd0;
        load_data = 32'd0;

        // Reset state.
        step();
        step();
        check("reset_arready", arready, 0);
        check("reset_rvalid", rvalid, 0);
        check("reset_rlast", rlast, 0);
        check("reset_rdata", rdata, 0);
        check("reset_rresp", rresp, 0);
        rst = 1'b0;
        step();
        check("first_cycle_arready", arready, 1);

        // Preload every word. Upper address bits and the byte offset are
        // scrambled to exercise the modulo addressing of the load port.
        for (int w = 0; w < DEPTH; w++) begin
            load_en   = 1'b1;
            load_addr = ($urandom & 32'hFFFF_C000) | (w << 2) | ($urandom & 32'h3);
            load_data = (w >= 'h40 && w <= 'h47) ? 32'(32'hA0 + w - 'h40) : $urandom;
            mem_m[w]  = load_data;
            step();
        end
        load_en = 1'b0;
        step();

        // 8-beat burst with rready held high; data should read 0xA0..0xA7.
        burst(32'h100, 7, 0, -1, 0, 32'd0, -1);
        check("directed_word_0x47", mem_m['h47], 32'hA7);
        // Same burst with rready stalls.
        burst(32'h100, 7, 1, -1, 0, 32'd0, -1);
        // Single beat.
        burst(32'h4, 0, 0, -1, 0, 32'd0, -1);
        // Load word 0x45 while the beat for 0x42 is presented.
        burst(32'h100, 7, 0, 2, 'h45, 32'hDEAD_BEEF, -1);
        check("model_word_0x45", mem_m['h45], 32'hDEAD_BEEF);
        // Burst across the top of memory.
        burst(32'h3FFC, 1, 0, -1, 0, 32'd0, -1);
        // Reset on beat 3, then confirm the next AR is served. Memory must survive rst.
        burst(32'h100, 7, 0, -1, 0, 32'd0, 2);
        burst(32'h100, 7, 0, -1, 0, 32'd0, -1);
        // Maximum burst length, starting near the top so the burst crosses the end.
        burst(32'h3F00 | ($urandom & 32'h3), 255, 2, -1, 0, 32'd0, -1);

        // Random bursts: mostly in range, some near the top, some far out of range.
        for (int t = 0; t < 30; t++) begin
            case ($urandom_range(0, 2))
                0:       a = $urandom_range(0, 32'h3FFF);
                1:       a = $urandom_range(32'h3F80, 32'h3FFF);
                default: a = $urandom_range(0, 32'h7FFF_FFFF);
            endcase
            burst(a, $urandom_range(0, 15), 2, -1, 0, 32'd0, -1);
            repeat ($urandom_range(0, 2)) step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
